// File: rtl/red_iterativa_serial_if.sv
// Handshake bundle for the bit-serial magnitude comparator. The operands and
// seeds go in, and the registered verdict comes back under valid/ready.
interface red_iterativa_serial_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         x_in;
    logic         y_in;
    logic         out_ready;
    logic         busy;
    logic         out_valid;
    logic         X;
    logic         Y;
    logic         eq;

    modport master (
        output start, a_in, b_in, x_in, y_in, out_ready,
        input  busy, out_valid, X, Y, eq
    );

    modport slave (
        input  start, a_in, b_in, x_in, y_in, out_ready,
        output busy, out_valid, X, Y, eq
    );
endinterface

// File: rtl/red_iterativa_serial.sv
// Bit-serial right-to-left magnitude comparator. It takes the bit-0 seed from
// the initial cell and then folds in bits 1..N-1, one bit per clock.
module red_iterativa_serial #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    red_iterativa_serial_if.slave   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  a_reg, a_next;
    logic [N-1:0]  b_reg, b_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          x_reg, x_next;
    logic          y_reg, y_next;

    logic [N-1:0]  a_sel;
    logic [N-1:0]  b_sel;
    logic          a_bit;
    logic          b_bit;
    logic          bits_eq;
    logic          last_idx;

    // One-hot decode of idx picks the operand bit that is processed this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel
            assign a_sel[gi] = a_reg[gi] & (idx_reg == IW'(gi));
            assign b_sel[gi] = b_reg[gi] & (idx_reg == IW'(gi));
        end
    endgenerate

    assign a_bit    = |a_sel;
    assign b_bit    = |b_sel;
    assign bits_eq  = ~(a_bit ^ b_bit);
    assign last_idx = (idx_reg == IW'(N - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            x_reg     <= 1'b0;
            y_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_next   = bus.a_in;
                    b_next   = bus.b_in;
                    // Each flag is masked by the other seed, so an illegal 1/1 seed pair loads as 0/0.
                    x_next   = bus.x_in & ~bus.y_in;
                    y_next   = bus.y_in & ~bus.x_in;
                    idx_next = IW'(1);
                    state_next = (N > 1) ? RUN : DONE;
                end
            end
            RUN: begin
                x_next = (a_bit & ~b_bit) | (bits_eq & x_reg);
                y_next = (~a_bit & b_bit) | (bits_eq & y_reg);
                if (last_idx) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.X         = x_reg;
    assign bus.Y         = y_reg;
    assign bus.eq        = ~x_reg & ~y_reg;
endmodule

// File: tb/tb_red_iterativa_serial.sv
// Bench for red_iterativa_serial. It uses a vector table against an 8-bit instance,
// plus hand sequences for reset abort and the 1-bit width.
module tb_red_iterativa_serial;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    red_iterativa_serial_if #(.N(8)) bus8 ();
    red_iterativa_serial_if #(.N(1)) bus1 ();

    red_iterativa_serial #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    red_iterativa_serial #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       xi;
        logic       yi;
        logic       ex;
        logic       ey;
        logic       eqe;
        int         hold;
    } vec_t;

    typedef struct {
        logic ex;
        logic ey;
        logic eqe;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at a negedge. Drives one comparison through dut8 and checks it against the scoreboard.
    task automatic run_cmp(input vec_t v, input int n);
        exp_t e;
        int   cyc;
        string tag;
        tag = $sformatf("v%0d", n);
        exp_q.push_back('{v.ex, v.ey, v.eqe});
        bus8.a_in  = v.a;
        bus8.b_in  = v.b;
        bus8.x_in  = v.xi;
        bus8.y_in  = v.yi;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus8.busy), 32'd1);
        cyc = 1;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd8);
        e = exp_q.pop_front();
        chk({tag, "_X"},  32'(bus8.X),  32'(e.ex));
        chk({tag, "_Y"},  32'(bus8.Y),  32'(e.ey));
        chk({tag, "_eq"}, 32'(bus8.eq), 32'(e.eqe));
        for (int h = 0; h < v.hold; h++) begin
            bus8.start = (h % 2 == 0);
            bus8.a_in  = 8'h00;
            bus8.b_in  = 8'hFF;
            bus8.x_in  = 1'b0;
            bus8.y_in  = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus8.out_valid), 32'd1);
            chk({tag, "_hold_X"},     32'(bus8.X),         32'(e.ex));
        end
        bus8.start     = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus8.out_valid), 32'd0);
        chk({tag, "_busy_drop"},  32'(bus8.busy),      32'd0);
        chk({tag, "_X_held"},     32'(bus8.X),         32'(e.ex));
        if (v.hold > 0) begin
            @(negedge clk);
            chk({tag, "_idle_stays"}, 32'(bus8.busy), 32'd0);
        end
        $display("txn %s a=%02h b=%02h X=%0b Y=%0b eq=%0b lat=%0d", tag, v.a, v.b,
                 bus8.X, bus8.Y, bus8.eq, cyc);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[6] = '{8'h7E, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[7] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};

        reset          = 1'b0;
        bus8.start     = 1'b0;
        bus8.a_in      = '0;
        bus8.b_in      = '0;
        bus8.x_in      = 1'b0;
        bus8.y_in      = 1'b0;
        bus8.out_ready = 1'b0;
        bus1.start     = 1'b0;
        bus1.a_in      = '0;
        bus1.b_in      = '0;
        bus1.x_in      = 1'b0;
        bus1.y_in      = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(bus8.busy),      32'd0);
        chk("rst_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_X",     32'(bus8.X),         32'd0);
        chk("rst_Y",     32'(bus8.Y),         32'd0);
        chk("rst_eq",    32'(bus8.eq),        32'd1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmp(vecs[i], i);
            @(negedge clk);
        end

        // Abort partway through a run: A=FF, B=00 would otherwise finish with X=1.
        bus8.a_in  = 8'hFF;
        bus8.b_in  = 8'h00;
        bus8.x_in  = 1'b1;
        bus8.y_in  = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy",  32'(bus8.busy),      32'd0);
        chk("abort_valid", 32'(bus8.out_valid), 32'd0);
        chk("abort_X",     32'(bus8.X),         32'd0);
        chk("abort_Y",     32'(bus8.Y),         32'd0);
        $display("txn abort busy=%0b valid=%0b X=%0b Y=%0b", bus8.busy, bus8.out_valid,
                 bus8.X, bus8.Y);
        run_cmp('{8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0}, 8);
        @(negedge clk);

        // A one-bit instance resolves entirely from the seed.
        bus1.a_in  = 1'b1;
        bus1.b_in  = 1'b0;
        bus1.x_in  = 1'b1;
        bus1.y_in  = 1'b0;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        chk("n1_valid", 32'(bus1.out_valid), 32'd1);
        chk("n1_X",     32'(bus1.X),         32'd1);
        chk("n1_Y",     32'(bus1.Y),         32'd0);
        chk("n1_eq",    32'(bus1.eq),        32'd0);
        $display("txn n1 a=1 b=0 valid=%0b X=%0b Y=%0b", bus1.out_valid, bus1.X, bus1.Y);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        chk("n1_valid_drop", 32'(bus1.out_valid), 32'd0);
        chk("n1_busy_drop",  32'(bus1.busy),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
